// File: rtl/avalon_ram_arbiter_if.sv
// Avalon-MM style bus bundle shared by the CPU-side ports and the RAM-side port
// of avalon_ram_arbiter; the RAM side carries a waitrequest driven toward the RAM.
interface avalon_ram_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

  // The arbiter sequences the RAM, so it owns waitrequest on that side.
  modport sequencer (
    output address, read, write, writedata, byteenable, waitrequest,
    input  readdata
  );

  modport ram (
    input  address, read, write, writedata, byteenable, waitrequest,
    output readdata
  );
endinterface

// File: rtl/avalon_ram_arbiter.sv
// Round-robin arbiter sharing one Avalon RAM between m0 (fetch) and m1 (data).
// Optional macro ARB_PERF_COUNT_EN adds saturating grant/contention counters.
module avalon_ram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  avalon_ram_arbiter_if.slave        m0,
  avalon_ram_arbiter_if.slave        m1,
  avalon_ram_arbiter_if.sequencer    s
`ifdef ARB_PERF_COUNT_EN
  ,
  output logic [31:0]                m0_grants,
  output logic [31:0]                m1_grants,
  output logic [31:0]                contention
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] s_address_q, s_address_d;
  logic [31:0] s_writedata_q, s_writedata_d;
  logic [3:0]  s_byteenable_q, s_byteenable_d;
  logic        s_read_q, s_read_d;
  logic        s_write_q, s_write_d;

  logic        m0_req, m1_req, pick;

  assign m0_req = m0.read | m0.write;
  assign m1_req = m1.read | m1.write;

  // On a tie the master that did not win last time gets the slot.
  assign pick = (m0_req & m1_req) ? ~last_grant_q : m1_req;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    s_address_d    = s_address_q;
    s_writedata_d  = s_writedata_q;
    s_byteenable_d = s_byteenable_q;
    s_read_d       = s_read_q;
    s_write_d      = s_write_q;
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          grant_d        = pick;
          s_address_d    = pick ? m1.address    : m0.address;
          s_writedata_d  = pick ? m1.writedata  : m0.writedata;
          s_byteenable_d = pick ? m1.byteenable : m0.byteenable;
          s_write_d      = pick ? m1.write      : m0.write;
          s_read_d       = (pick ? m1.read : m0.read) & ~(pick ? m1.write : m0.write);
          cnt_d          = 4'(WAIT_CYCLES);
          state_d        = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        last_grant_d = grant_q;
        s_read_d     = 1'b0;
        s_write_d    = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= 4'd0;
      s_address_q    <= 32'd0;
      s_writedata_q  <= 32'd0;
      s_byteenable_q <= 4'd0;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      s_address_q    <= s_address_d;
      s_writedata_q  <= s_writedata_d;
      s_byteenable_q <= s_byteenable_d;
      s_read_q       <= s_read_d;
      s_write_q      <= s_write_d;
    end
  end

  // The RAM acts on the falling edge of its waitrequest, i.e. entry into ACCESS.
  assign s.waitrequest  = (state_q != ACCESS);
  assign s.address      = s_address_q;
  assign s.writedata    = s_writedata_q;
  assign s.byteenable   = s_byteenable_q;
  assign s.read         = s_read_q;
  assign s.write        = s_write_q;

  assign m0.waitrequest = m0_req & ~((state_q == ACCESS) & ~grant_q);
  assign m1.waitrequest = m1_req & ~((state_q == ACCESS) &  grant_q);
  assign m0.readdata    = s.readdata;
  assign m1.readdata    = s.readdata;

`ifdef ARB_PERF_COUNT_EN
  logic [31:0] m0_grants_q, m0_grants_d;
  logic [31:0] m1_grants_q, m1_grants_d;
  logic [31:0] contention_q, contention_d;

  always_comb begin
    m0_grants_d  = m0_grants_q;
    m1_grants_d  = m1_grants_q;
    contention_d = contention_q;
    if (state_q == ACCESS && !grant_q && m0_grants_q != '1) m0_grants_d = m0_grants_q + 32'd1;
    if (state_q == ACCESS &&  grant_q && m1_grants_q != '1) m1_grants_d = m1_grants_q + 32'd1;
    if (state_q == IDLE && m0_req && m1_req && contention_q != '1)
      contention_d = contention_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_grants_q  <= 32'd0;
      m1_grants_q  <= 32'd0;
      contention_q <= 32'd0;
    end else begin
      m0_grants_q  <= m0_grants_d;
      m1_grants_q  <= m1_grants_d;
      contention_q <= contention_d;
    end
  end

  assign m0_grants  = m0_grants_q;
  assign m1_grants  = m1_grants_q;
  assign contention = contention_q;
`endif

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// Scoreboard bench for avalon_ram_arbiter: a WAIT_CYCLES=2 instance with a small RAM
// model and a WAIT_CYCLES=0 instance for back-to-back reads; ARB_PERF_COUNT_EN aware.
`timescale 1ns/1ps
module tb_avalon_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_ram_arbiter_if m0_bus ();
  avalon_ram_arbiter_if m1_bus ();
  avalon_ram_arbiter_if s_bus ();
  avalon_ram_arbiter_if z0_bus ();
  avalon_ram_arbiter_if z1_bus ();
  avalon_ram_arbiter_if zs_bus ();

  // Port 0/1: masters of the main instance, port 2: m0 of the zero-wait instance.
  logic [31:0] drv_addr [3];
  logic [31:0] drv_wdata [3];
  logic [3:0]  drv_be [3];
  logic        drv_rd [3];
  logic        drv_wr [3];
  logic        obs_wait [3];
  logic [31:0] obs_rdata [3];

  assign m0_bus.address = drv_addr[0];  assign m0_bus.writedata = drv_wdata[0];
  assign m0_bus.byteenable = drv_be[0]; assign m0_bus.read = drv_rd[0];
  assign m0_bus.write = drv_wr[0];
  assign m1_bus.address = drv_addr[1];  assign m1_bus.writedata = drv_wdata[1];
  assign m1_bus.byteenable = drv_be[1]; assign m1_bus.read = drv_rd[1];
  assign m1_bus.write = drv_wr[1];
  assign z0_bus.address = drv_addr[2];  assign z0_bus.writedata = drv_wdata[2];
  assign z0_bus.byteenable = drv_be[2]; assign z0_bus.read = drv_rd[2];
  assign z0_bus.write = drv_wr[2];
  assign z1_bus.address = 32'd0;        assign z1_bus.writedata = 32'd0;
  assign z1_bus.byteenable = 4'd0;      assign z1_bus.read = 1'b0;
  assign z1_bus.write = 1'b0;

  assign obs_wait[0] = m0_bus.waitrequest;  assign obs_rdata[0] = m0_bus.readdata;
  assign obs_wait[1] = m1_bus.waitrequest;  assign obs_rdata[1] = m1_bus.readdata;
  assign obs_wait[2] = z0_bus.waitrequest;  assign obs_rdata[2] = z0_bus.readdata;

`ifdef ARB_PERF_COUNT_EN
  logic [31:0] m0_grants, m1_grants, contention;
  logic [31:0] z_m0_grants, z_m1_grants, z_contention;
`endif

  avalon_ram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus), .s(s_bus)
`ifdef ARB_PERF_COUNT_EN
    , .m0_grants(m0_grants), .m1_grants(m1_grants), .contention(contention)
`endif
  );

  avalon_ram_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .m0(z0_bus), .m1(z1_bus), .s(zs_bus)
`ifdef ARB_PERF_COUNT_EN
    , .m0_grants(z_m0_grants), .m1_grants(z_m1_grants), .contention(z_contention)
`endif
  );

  // RAM model: combinational read, byte-masked write committed at the end of ACCESS.
  logic [31:0] mem [256];
  logic [31:0] mem0 [2];
  logic [31:0] be_mask;

  assign be_mask = {{8{s_bus.byteenable[3]}}, {8{s_bus.byteenable[2]}},
                    {8{s_bus.byteenable[1]}}, {8{s_bus.byteenable[0]}}};
  assign s_bus.readdata  = mem[s_bus.address[9:2]];
  assign zs_bus.readdata = mem0[zs_bus.address[2]];

  always @(posedge clk)
    if (!s_bus.waitrequest && s_bus.write)
      mem[s_bus.address[9:2]] <= (mem[s_bus.address[9:2]] & ~be_mask) |
                                 (s_bus.writedata & be_mask);

  typedef struct {
    int          port;
    bit          is_read;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   done_cnt [3];
  int   num_checks = 0;
  int   num_fail = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Completion monitor: pops the oldest expectation for the port that completed.
  always @(negedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if ((drv_rd[p] || drv_wr[p]) && !obs_wait[p]) begin
        int hit;
        hit = -1;
        foreach (sb_q[i]) if (hit < 0 && sb_q[i].port == p) hit = i;
        done_cnt[p]++;
        checkOutput($sformatf("p%0d_sb_entry", p), 32'(hit >= 0), 32'd1);
        if (hit >= 0) begin
          if (sb_q[hit].is_read)
            checkOutput($sformatf("p%0d_readdata", p), obs_rdata[p], sb_q[hit].data);
          if (sb_q[hit].due >= 0)
            checkOutput($sformatf("p%0d_done_cycle", p), 32'(cyc), 32'(sb_q[hit].due));
          sb_q.delete(hit);
        end
      end
    end
  end

  // Called just after a posedge; returns just after the posedge ending the completion cycle.
  task automatic applyStimulus(input int p, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] exp_rd, input int lat);
    exp_t e;
    int   seen;
    int   n;
    e.port    = p;
    e.is_read = !wr;
    e.data    = exp_rd;
    e.due     = (lat < 0) ? -1 : cyc + lat;
    sb_q.push_back(e);
    drv_addr[p]  = addr;
    drv_wdata[p] = wdata;
    drv_be[p]    = be;
    drv_rd[p]    = !wr;
    drv_wr[p]    = wr;
    seen = done_cnt[p];
    n = 0;
    while (done_cnt[p] == seen && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("p%0d_completed", p), 32'(done_cnt[p] - seen), 32'd1);
    @(posedge clk);
    #1;
    drv_rd[p] = 1'b0;
    drv_wr[p] = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drv_addr[p] = 32'd0; drv_wdata[p] = 32'd0; drv_be[p] = 4'd0;
      drv_rd[p] = 1'b0; drv_wr[p] = 1'b0; done_cnt[p] = 0;
    end
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    mem[4] <= 32'h11223344;
    mem[2] <= 32'h12345678;
    mem0[0] = 32'hA5A50001;
    mem0[1] = 32'h5A5A0002;
    resetDut();

    checkOutput("rst_s_waitrequest", 32'(s_bus.waitrequest), 32'd1);
    checkOutput("rst_s_read", 32'(s_bus.read), 32'd0);
    checkOutput("rst_s_write", 32'(s_bus.write), 32'd0);
    checkOutput("rst_s_address", s_bus.address, 32'd0);
    checkOutput("rst_s_byteenable", 32'(s_bus.byteenable), 32'd0);
    checkOutput("rst_m0_wait_idle", 32'(m0_bus.waitrequest), 32'd0);

    // Single read: completes exactly WAIT_CYCLES+1 cycles after the request.
    applyStimulus(0, 1'b0, 32'h00000010, 32'd0, 4'hF, 32'h11223344, 3);

    // Partial write then read back through the same master.
    applyStimulus(1, 1'b1, 32'h80000004, 32'hDEADBEEF, 4'b0011, 32'd0, 3);
    applyStimulus(1, 1'b0, 32'h80000004, 32'd0, 4'hF, 32'h0000BEEF, 3);

    // Write interrupted by reset during WAIT must not reach the RAM.
    drv_addr[1] = 32'h80000008; drv_wdata[1] = 32'hCAFEF00D;
    drv_be[1] = 4'hF; drv_wr[1] = 1'b1;
    @(posedge clk); #1;
    checkOutput("t4_s_write_latched", 32'(s_bus.write), 32'd1);
    checkOutput("t4_s_addr_latched", s_bus.address, 32'h80000008);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drv_wr[1] = 1'b0;
    checkOutput("t4_s_waitrequest", 32'(s_bus.waitrequest), 32'd1);
    checkOutput("t4_s_write_clr", 32'(s_bus.write), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_ram_unchanged", mem[2], 32'h12345678);
    applyStimulus(1, 1'b1, 32'h80000008, 32'hCAFEF00D, 4'hF, 32'd0, 3);
    applyStimulus(0, 1'b0, 32'h80000008, 32'd0, 4'hF, 32'hCAFEF00D, 3);

    // Zero wait states: back-to-back reads complete two cycles apart.
    applyStimulus(2, 1'b0, 32'h00000000, 32'd0, 4'hF, 32'hA5A50001, 1);
    applyStimulus(2, 1'b0, 32'h00000004, 32'd0, 4'hF, 32'h5A5A0002, 1);

    // Continuous contention right after reset: m0, m1, m0, m1, one transfer every 4 cycles.
    resetDut();
    fork
      begin
        applyStimulus(0, 1'b0, 32'h00000010, 32'd0, 4'hF, 32'h11223344, 3);
        applyStimulus(0, 1'b0, 32'h80000008, 32'd0, 4'hF, 32'hCAFEF00D, 7);
      end
      begin
        applyStimulus(1, 1'b0, 32'h80000008, 32'd0, 4'hF, 32'hCAFEF00D, 7);
        applyStimulus(1, 1'b0, 32'h80000004, 32'd0, 4'hF, 32'h0000BEEF, 7);
      end
    join
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef ARB_PERF_COUNT_EN
    checkOutput("perf_m0_grants", m0_grants, 32'd2);
    checkOutput("perf_m1_grants", m1_grants, 32'd2);
    checkOutput("perf_contention_ge2", 32'(contention >= 32'd2), 32'd1);
    resetDut();
    checkOutput("perf_m0_rst", m0_grants, 32'd0);
    checkOutput("perf_m1_rst", m1_grants, 32'd0);
    checkOutput("perf_cont_rst", contention, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
